// File: rtl/uart_pkt_pkg.sv
// Shared constants and FSM state type for the IMU packet scheduler.
package uart_pkt_pkg;

    localparam logic [7:0]  SYNC0     = 8'hA5;
    localparam logic [7:0]  SYNC1     = 8'h5A;
    localparam int unsigned HDR_BYTES = 3;

    typedef enum logic [2:0] {
        StIdle,
        StLoad,
        StStart,
        StAck,
        StDone
    } state_e;

endpackage

// File: rtl/uart_pkt_sched.sv
// Frames IMU sample words into A5 5A SEQ payload CKSUM packets and paces uart_tx
// one byte at a time, holding one pending sample and counting drops.
module uart_pkt_sched
    import uart_pkt_pkg::*;
#(
    parameter int unsigned NUM_WORDS   = 7,
    parameter int unsigned ACK_TIMEOUT = 4
) (
    input  logic                    clk_i,
    input  logic                    rst_ni,
    input  logic                    enable_i,
    input  logic                    sample_valid_i,
    input  logic [16*NUM_WORDS-1:0] sample_i,
    input  logic                    tx_busy_i,
    output logic                    tx_start_o,
    output logic [7:0]              tx_data_o,
    output logic                    pkt_busy_o,
    output logic [7:0]              seq_o,
    output logic [15:0]             drop_cnt_o
);

    localparam int unsigned SampleW  = 16 * NUM_WORDS;
    localparam int unsigned NumBytes = HDR_BYTES + 2 * NUM_WORDS + 1;
    localparam logic [7:0]  LastIdx  = 8'(NumBytes - 1);
    localparam logic [7:0]  SeqIdx   = 8'(HDR_BYTES - 1);
    localparam int unsigned AckW     = $clog2(ACK_TIMEOUT + 1);

    state_e             state_q;
    logic [SampleW-1:0] pend_q;
    logic               pend_full_q;
    logic [SampleW-1:0] work_q;
    logic [7:0]         idx_q;
    logic [7:0]         cksum_q;
    logic [AckW-1:0]    ack_cnt_q;
    logic               tx_start_q;
    logic [7:0]         tx_data_q;
    logic               pkt_busy_q;
    logic [7:0]         seq_q;
    logic [15:0]        drop_q;

    logic               consume;
    logic [7:0]         pay_idx;
    logic [15:0]        cur_word;
    logic [7:0]         cur_byte;

    assign consume = (state_q == StIdle) && pend_full_q;

    // Payload bytes follow the header: word (idx-3)/2, high byte on even offsets.
    always_comb begin
        pay_idx  = idx_q - 8'(HDR_BYTES);
        cur_word = '0;
        for (int k = 0; k < NUM_WORDS; k++) begin
            if (pay_idx[7:1] == 7'(k)) begin
                cur_word = work_q[16*k +: 16];
            end
        end
        if (idx_q == 8'd0) begin
            cur_byte = SYNC0;
        end else if (idx_q == 8'd1) begin
            cur_byte = SYNC1;
        end else if (idx_q == SeqIdx) begin
            cur_byte = seq_q;
        end else if (idx_q == LastIdx) begin
            cur_byte = cksum_q;
        end else begin
            cur_byte = pay_idx[0] ? cur_word[7:0] : cur_word[15:8];
        end
    end

    // A strobe landing in the same cycle IDLE empties pending refills it without a drop.
    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            pend_q      <= '0;
            pend_full_q <= 1'b0;
            drop_q      <= '0;
        end else if (enable_i && sample_valid_i) begin
            if (!pend_full_q || consume) begin
                pend_q      <= sample_i;
                pend_full_q <= 1'b1;
            end else if (drop_q != 16'hFFFF) begin
                drop_q <= drop_q + 16'd1;
            end
        end else if (consume) begin
            pend_full_q <= 1'b0;
        end
    end

    always_ff @(posedge clk_i or negedge rst_ni) begin
        if (!rst_ni) begin
            state_q    <= StIdle;
            work_q     <= '0;
            idx_q      <= '0;
            cksum_q    <= '0;
            ack_cnt_q  <= '0;
            tx_start_q <= 1'b0;
            tx_data_q  <= '0;
            pkt_busy_q <= 1'b0;
            seq_q      <= '0;
        end else begin
            tx_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (pend_full_q) begin
                        work_q     <= pend_q;
                        idx_q      <= '0;
                        cksum_q    <= '0;
                        pkt_busy_q <= 1'b1;
                        state_q    <= StLoad;
                    end
                end
                StLoad: begin
                    tx_data_q <= cur_byte;
                    if (!tx_busy_i) begin
                        tx_start_q <= 1'b1;
                        state_q    <= StStart;
                        if (idx_q >= SeqIdx && idx_q != LastIdx) begin
                            cksum_q <= cksum_q ^ cur_byte;
                        end
                    end
                end
                StStart: begin
                    ack_cnt_q <= '0;
                    state_q   <= StAck;
                end
                StAck: begin
                    // A missing busy rise is treated as a sent byte so the line never locks up.
                    if (tx_busy_i || ack_cnt_q == AckW'(ACK_TIMEOUT - 1)) begin
                        state_q <= StDone;
                    end else begin
                        ack_cnt_q <= ack_cnt_q + 1'b1;
                    end
                end
                StDone: begin
                    if (!tx_busy_i) begin
                        if (idx_q == LastIdx) begin
                            seq_q      <= seq_q + 8'd1;
                            pkt_busy_q <= 1'b0;
                            state_q    <= StIdle;
                        end else begin
                            idx_q   <= idx_q + 8'd1;
                            state_q <= StLoad;
                        end
                    end
                end
                default: state_q <= StIdle;
            endcase
        end
    end

    assign tx_start_o = tx_start_q;
    assign tx_data_o  = tx_data_q;
    assign pkt_busy_o = pkt_busy_q;
    assign seq_o      = seq_q;
    assign drop_cnt_o = drop_q;

endmodule

// File: tb/tb_uart_pkt_sched.sv
// Directed and randomized checks of uart_pkt_sched against a packet-level model,
// with a behavioural uart_tx busy responder.
module tb_uart_pkt_sched;

    localparam int unsigned NW = 7;
    localparam int unsigned SW = 16 * NW;

    logic          clk = 1'b0;
    logic          rst_ni = 1'b0;
    logic          enable_i = 1'b0;
    logic          sample_valid_i = 1'b0;
    logic [SW-1:0] sample_i = '0;
    logic          tx_busy_i = 1'b0;
    logic          tx_start_o;
    logic [7:0]    tx_data_o;
    logic          pkt_busy_o;
    logic [7:0]    seq_o;
    logic [15:0]   drop_cnt_o;

    int            n_checks = 0;
    int            n_fail = 0;
    logic [7:0]    rx_q[$];
    logic [7:0]    exp_q[$];
    logic [7:0]    exp_seq = '0;
    logic [15:0]   exp_drop = '0;
    bit            no_busy = 1'b0;
    logic          prev_start = 1'b0;

    always #5 clk = ~clk;

    uart_pkt_sched #(
        .NUM_WORDS   (NW),
        .ACK_TIMEOUT (4)
    ) dut (
        .clk_i          (clk),
        .rst_ni         (rst_ni),
        .enable_i       (enable_i),
        .sample_valid_i (sample_valid_i),
        .sample_i       (sample_i),
        .tx_busy_i      (tx_busy_i),
        .tx_start_o     (tx_start_o),
        .tx_data_o      (tx_data_o),
        .pkt_busy_o     (pkt_busy_o),
        .seq_o          (seq_o),
        .drop_cnt_o     (drop_cnt_o)
    );

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    // Line monitor: every start pulse delivers one byte and must see an idle uart_tx.
    always @(negedge clk) begin
        if (tx_start_o) begin
            rx_q.push_back(tx_data_o);
            chk("start_while_busy", 32'(tx_busy_i), 32'd0);
            chk("start_one_cycle", 32'(prev_start), 32'd0);
        end
        prev_start <= tx_start_o;
    end

    // uart_tx stand-in: busy rises 1..3 cycles after the start pulse, holds 1..4 cycles.
    initial begin
        forever begin
            @(posedge clk);
            #1;
            if (tx_start_o && !no_busy) begin : respond
                int d;
                int h;
                d = $urandom_range(1, 3);
                h = $urandom_range(1, 4);
                repeat (d) @(posedge clk);
                #1 tx_busy_i = 1'b1;
                repeat (h) @(posedge clk);
                #1 tx_busy_i = 1'b0;
            end
        end
    end

    initial begin
        #3_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    function automatic logic [SW-1:0] rand_sample();
        logic [SW-1:0] s;
        for (int k = 0; k < NW; k++) s[16*k +: 16] = 16'($urandom);
        return s;
    endfunction

    // Reference framing: sync, seq, words MSB first, XOR of seq and payload.
    task automatic expect_pkt(input logic [SW-1:0] s);
        logic [7:0] ck;
        logic [7:0] hi;
        logic [7:0] lo;
        exp_q.push_back(8'hA5);
        exp_q.push_back(8'h5A);
        exp_q.push_back(exp_seq);
        ck = exp_seq;
        for (int k = 0; k < NW; k++) begin
            hi = s[16*k+8 +: 8];
            lo = s[16*k +: 8];
            exp_q.push_back(hi);
            exp_q.push_back(lo);
            ck = ck ^ hi ^ lo;
        end
        exp_q.push_back(ck);
        exp_seq = exp_seq + 8'd1;
    endtask

    task automatic strobe(input logic [SW-1:0] s);
        @(negedge clk);
        sample_i       = s;
        sample_valid_i = 1'b1;
        @(negedge clk);
        sample_valid_i = 1'b0;
    endtask

    task automatic wait_pkt_busy(input string tag);
        int cyc = 0;
        while (!pkt_busy_o && cyc < 100) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_busy_timeout"}, 32'(pkt_busy_o), 32'd1);
    endtask

    task automatic drain(input string tag);
        int cyc = 0;
        while ((rx_q.size() < exp_q.size() || pkt_busy_o) && cyc < 20000) begin
            @(negedge clk);
            cyc++;
        end
        chk({tag, "_timeout"}, 32'(cyc < 20000), 32'd1);
        chk({tag, "_len"}, 32'(rx_q.size()), 32'(exp_q.size()));
        while (exp_q.size() > 0 && rx_q.size() > 0) begin
            chk({tag, "_byte"}, 32'(rx_q.pop_front()), 32'(exp_q.pop_front()));
        end
        rx_q.delete();
        exp_q.delete();
        chk({tag, "_seq_o"}, 32'(seq_o), 32'(exp_seq));
        chk({tag, "_drop"}, 32'(drop_cnt_o), 32'(exp_drop));
        chk({tag, "_pkt_busy"}, 32'(pkt_busy_o), 32'd0);
    endtask

    task automatic check_reset_vals(input string tag);
        chk({tag, "_tx_start"}, 32'(tx_start_o), 32'd0);
        chk({tag, "_tx_data"}, 32'(tx_data_o), 32'd0);
        chk({tag, "_pkt_busy"}, 32'(pkt_busy_o), 32'd0);
        chk({tag, "_seq"}, 32'(seq_o), 32'd0);
        chk({tag, "_drop"}, 32'(drop_cnt_o), 32'd0);
    endtask

    initial begin
        logic [SW-1:0] a;
        logic [SW-1:0] b;
        logic [SW-1:0] c;
        int            cyc;

        enable_i = 1'b1;
        repeat (3) @(negedge clk);
        check_reset_vals("reset");
        rst_ni = 1'b1;
        repeat (2) @(negedge clk);

        // Fixed words 0x0100..0x0706.
        for (int k = 0; k < NW; k++) a[16*k +: 16] = {8'(k + 1), 8'(k)};
        strobe(a);
        expect_pkt(a);
        drain("pkt_fixed");

        // Second sample pends during a packet, third is dropped.
        a = rand_sample();
        b = rand_sample();
        c = rand_sample();
        strobe(a);
        expect_pkt(a);
        wait_pkt_busy("overlap");
        strobe(b);
        expect_pkt(b);
        repeat (5) @(negedge clk);
        strobe(c);
        exp_drop = exp_drop + 16'd1;
        drain("overlap");

        // Strobe on the very cycle IDLE consumes pending: refill, no drop.
        a = rand_sample();
        b = rand_sample();
        @(negedge clk);
        sample_i       = a;
        sample_valid_i = 1'b1;
        @(negedge clk);
        sample_i       = b;
        @(negedge clk);
        sample_valid_i = 1'b0;
        expect_pkt(a);
        expect_pkt(b);
        drain("same_cycle");

        // uart_tx never acknowledges: every byte must still go out via the timeout.
        no_busy = 1'b1;
        a = rand_sample();
        strobe(a);
        expect_pkt(a);
        drain("ack_timeout");
        no_busy = 1'b0;

        // enable_i drops mid-packet: current and pending packets finish, strobes ignored.
        a = rand_sample();
        b = rand_sample();
        strobe(a);
        expect_pkt(a);
        wait_pkt_busy("disable");
        strobe(b);
        expect_pkt(b);
        enable_i = 1'b0;
        for (int i = 0; i < 3; i++) begin
            strobe(rand_sample());
            repeat (2) @(negedge clk);
        end
        drain("disable");
        repeat (40) @(negedge clk);
        chk("disable_no_new_pkt", 32'(rx_q.size()), 32'd0);
        chk("disable_idle", 32'(pkt_busy_o), 32'd0);
        enable_i = 1'b1;

        // Reset mid-packet, then a fresh packet starts again at seq 0.
        strobe(rand_sample());
        cyc = 0;
        while (rx_q.size() < 5 && cyc < 2000) begin
            @(negedge clk);
            cyc++;
        end
        chk("midreset_reach", 32'(rx_q.size() >= 5), 32'd1);
        rst_ni = 1'b0;
        @(negedge clk);
        check_reset_vals("midreset");
        rst_ni = 1'b1;
        cyc = 0;
        while (tx_busy_i && cyc < 20) begin
            @(negedge clk);
            cyc++;
        end
        @(negedge clk);
        rx_q.delete();
        exp_q.delete();
        exp_seq  = '0;
        exp_drop = '0;
        a = rand_sample();
        strobe(a);
        expect_pkt(a);
        drain("after_reset");

        // Run the sequence number through a full wrap.
        for (int i = 0; i < 257; i++) begin
            a = rand_sample();
            strobe(a);
            expect_pkt(a);
            drain("wrap");
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
